ram_16k: RTL and testbench

RAM_16K -- requirements
Module: ram_16k

---
 rtl/ram_16k.sv | 49 ++++
 tb/tb_ram_16k.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_16k.sv
// rtl/ram_16k.sv - 16K-word RAM built from four 4K banks, combinational read, async clear
module ram_16k #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14
) (
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  clock,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] out,
   input  logic                  reset
);

   localparam int BANK_AW    = ADDR_WIDTH - 2;
   localparam int BANK_DEPTH = 1 << BANK_AW;

   logic [1:0]            bank_sel;
   logic [BANK_AW-1:0]    bank_idx;
   logic [DATA_WIDTH-1:0] bank_rd [0:3];

   assign bank_sel = address[ADDR_WIDTH-1 -: 2];
   assign bank_idx = address[BANK_AW-1:0];

   genvar b;
   generate
      for (b = 0; b < 4; b++) begin : g_bank
         logic [DATA_WIDTH-1:0] mem [0:BANK_DEPTH-1];
         logic                  bank_we;

         // only the addressed bank ever sees the write enable
         assign bank_we = load && (bank_sel == 2'(b));

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < BANK_DEPTH; i++) begin
                  mem[i] <= '0;
               end
            end else if (bank_we) begin
               mem[bank_idx] <= in;
            end
         end

         assign bank_rd[b] = mem[bank_idx];
      end
   endgenerate

   assign out = bank_rd[bank_sel];

endmodule

// File: tb/tb_ram_16k.sv
// tb/tb_ram_16k.sv - directed scoreboard bench for ram_16k
module tb_ram_16k;

   logic [15:0] data_in;
   logic        clock;
   logic        load;
   logic [13:0] address;
   logic [15:0] data_out;
   logic        reset;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q [$];
   string       tag_q [$];
   logic [15:0] model [int];

   ram_16k #(.DATA_WIDTH(16), .ADDR_WIDTH(14)) dut (
      .in      (data_in),
      .clock   (clock),
      .load    (load),
      .address (address),
      .out     (data_out),
      .reset   (reset)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] mval(input int a);
      if (model.exists(a)) return model[a];
      return 16'h0000;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
   endtask

   task automatic compare_next();
      logic [15:0] exp;
      string       tag;
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      checks++;
      assert (data_out === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, data_out, exp);
      end
   endtask

   task automatic read_check(input string tag, input int a);
      address = 14'(a);
      expect_out(tag, mval(a));
      #1;
      compare_next();
   endtask

   task automatic write_word(input int a, input logic [15:0] d);
      address = 14'(a);
      data_in = d;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      model[a] = d;
   endtask

   initial begin
      reset   = 1'b1;
      load    = 1'b0;
      data_in = 16'h0000;
      address = 14'd0;
      #2;
      read_check("reset_out_a0", 0);
      read_check("reset_out_a16383", 16383);
      tick();
      reset = 1'b0;
      model.delete();

      // write/read-back and hold with changing in
      write_word(5, 16'd3);
      read_check("wr_readback", 5);
      data_in = 16'd99;
      tick();
      tick();
      read_check("wr_hold_in_changed", 5);

      // no-write hold
      data_in = 16'd1234;
      address = 14'd5;
      repeat (3) tick();
      read_check("nowrite_hold_a5", 5);
      address = 14'd6;
      repeat (2) tick();
      read_check("nowrite_hold_a6", 6);

      // bank isolation
      write_word(0, 16'hAAAA);
      write_word(4096, 16'h5555);
      write_word(8192, 16'h1234);
      write_word(16383, 16'hFFFF);
      read_check("bank_a0", 0);
      read_check("bank_a4096", 4096);
      read_check("bank_a8192", 8192);
      read_check("bank_a16383", 16383);
      read_check("nbr_a1", 1);
      read_check("nbr_a4095", 4095);
      read_check("nbr_a16382", 16382);
      read_check("bank_a5_kept", 5);

      // read-during-write
      write_word(7, 16'd9);
      address = 14'd7;
      data_in = 16'd10;
      load    = 1'b1;
      expect_out("rdw_before_edge", 16'd9);
      #1;
      compare_next();
      @(posedge clock);
      #1;
      load = 1'b0;
      model[7] = 16'd10;
      expect_out("rdw_after_edge", 16'd10);
      compare_next();

      // async reset between edges
      #2;
      reset = 1'b1;
      model.delete();
      #1;
      read_check("areset_a0", 0);
      read_check("areset_a4096", 4096);
      read_check("areset_a8192", 8192);
      read_check("areset_a16383", 16383);
      read_check("areset_a7", 7);

      // reset dominates load
      address = 14'd5;
      data_in = 16'd77;
      load    = 1'b1;
      tick();
      load  = 1'b0;
      reset = 1'b0;
      read_check("reset_vs_load_a5", 5);

      // first write after reset release
      write_word(5, 16'd42);
      read_check("post_reset_write", 5);

      // address bit aliasing: one word per address bit
      for (int k = 0; k < 14; k++) begin
         write_word(1 << k, 16'(16'h0100 + k));
      end
      write_word(0, 16'hBEEF);
      for (int k = 0; k < 14; k++) begin
         read_check($sformatf("alias_bit%0d", k), 1 << k);
      end
      read_check("alias_a0", 0);
      read_check("alias_a5", 5);
      read_check("alias_a3", 3);

      // random writes against the model
      for (int n = 0; n < 12; n++) begin
         write_word(int'($urandom_range(0, 16383)), 16'($urandom));
      end
      foreach (model[a]) begin
         read_check($sformatf("rand_a%0d", a), a);
      end

      // reset mid-sequence discards everything
      write_word(100, 16'h1111);
      address = 14'd200;
      data_in = 16'h2222;
      load    = 1'b1;
      #2;
      reset = 1'b1;
      model.delete();
      tick();
      load  = 1'b0;
      reset = 1'b0;
      read_check("midseq_a100", 100);
      read_check("midseq_a200", 200);
      read_check("midseq_a0", 0);
      read_check("midseq_a16383", 16383);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
